seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Downstream consumer of the button-driven address counter and ROM data path.
//   Latches a 16-bit value as 4 hex digits and time-multiplexes them onto a
//   common 4-digit 7-segment display.
//   New values are double-buffered and applied only at frame boundaries, so the
//   display never shows a torn digit set.
// PARAMETERS
//   REFRESH_DIV  50000  clk cycles each digit stays lit (>=2); 4 in simulation
//   ACTIVE_LOW   1      1: an/seg/dp_n driven low = on; 0: high = on
// PORTS
//   clk        in   1   system clock, rising edge
//   clr        in   1   synchronous active-high reset
//   load       in   1   1-cycle strobe: capture value/dp into pending register
//   value      in   16  digit3=[15:12] .. digit0=[3:0], hex
//   dp         in   4   decimal point per digit, bit i = digit i
//   blank_lz   in   1   1: blank leading zero digits
//   an         out  4   digit enables, one-hot active, bit i = digit i
//   seg        out  7   segments {g,f,e,d,c,b,a}
//   dp_n       out  1   decimal point segment
//   frame_done out  1   1-cycle pulse as digit 3 slot ends
// BEHAVIOUR
//   Reset (clr=1 at posedge):
//     - pending, display, dp regs = 0; pend_valid = 0
//     - div = 0; digit index = 0
//     - an/seg/dp_n all inactive; frame_done = 0
//   Divider:
//     - div counts 0..REFRESH_DIV-1, then wraps to 0
//     - at wrap, digit index advances 0->1->2->3->0
//   frame_done:
//     - asserts for the single cycle where div wraps while index = 3
//   Load path:
//     - load=1 -> pending <= {value, dp}; pend_valid <= 1
//     - a later load before transfer overwrites pending (last wins)
//   Frame transfer (frame_done cycle):
//     - pend_valid=1 -> display <= pending; pend_valid <= 0
//     - load in the same cycle as frame_done: the new value/dp go straight to
//       display, pend_valid stays 0
//   Output stage (registered):
//     - an/seg/dp_n reflect the next cycle's digit index and display content
//     - first digit 0 pattern appears the cycle after clr deasserts
//     - exactly one an bit active at any time outside reset
//   Hex decode (active-high form, {g..a}):
//     0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101
//     7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110
//     E=1111001 F=1110001
//     ACTIVE_LOW inverts an, seg and dp_n
//   Leading-zero blanking (blank_lz=1):
//     - digit i (i>=1) is blanked when it and all higher digits are 0
//     - blanked: seg all off, an still scans; digit 0 is never blanked
//     - dp[i]=1 still lights dp on a blanked digit
//     - blank_lz is sampled live, not buffered
//   Reset mid-frame:
//     - clr wins over load and transfer
//     - pending and display contents are discarded
// TESTING  (REFRESH_DIV=4, ACTIVE_LOW=1)
//   - Reset held 3 cycles -> an=1111, seg=1111111, dp_n=1, frame_done=0;
//     after release an=1110, seg=1000000 (digit "0")
//   - load value=16'h12AF, dp=0000, mid-frame -> display unchanged until
//     frame_done; next frame shows digits F,A,2,1 on an=1110,1101,1011,0111,
//     each for 4 cycles
//   - Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows 2222
//   - load 16'h0305 coincident with frame_done -> 0305 displayed in the
//     immediately following frame
//   - blank_lz=1, value=16'h0000, dp=4'b0100 -> digit3 blanked; digit2 blank
//     with dp_n=0; digit1 blank; digit0 shows "0"
//   - clr asserted mid-frame after a pending load -> all outputs inactive;
//     after release the display shows 0000, not the pending value

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundles the load-side inputs and display-side outputs of the 7-segment scan driver.
// Master drives the value to show; the slave (the driver) owns the display pins.
interface seg7_scan_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output load, value, dp, blank_lz,
        input  an, seg, dp_n, frame_done
    );

    modport slave (
        input  load, value, dp, blank_lz,
        output an, seg, dp_n, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexes a double-buffered 16-bit hex value onto a 4-digit 7-segment display.
// A new value is swapped into the display register only on a frame boundary.
//
// state | meaning
// DIG0  | digit 0 (value[3:0]) lit
// DIG1  | digit 1 (value[7:4]) lit
// DIG2  | digit 2 (value[11:8]) lit
// DIG3  | digit 3 (value[15:12]) lit; frame ends as this slot expires
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    seg7_scan_if.slave  bus
);
    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

    // {value[15:0], dp[3:0]}
    logic [19:0]   pend_q, pend_d, disp_q, disp_d;
    logic          pend_valid_q, pend_valid_d;
    logic [DW-1:0] div_q, div_d;
    digit_e        idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_n_q, dp_n_d;
    logic          wrap, frame_end;
    logic [3:0]    nib;
    logic          blank, dp_hi;
    logic [3:0]    an_hi;
    logic [6:0]    seg_hi;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    always_comb begin
        wrap      = (div_q == DIV_LAST);
        frame_end = wrap && (idx_q == DIG3);
        div_d     = wrap ? '0 : div_q + 1'b1;
        idx_d     = wrap ? digit_e'(idx_q + 2'd1) : idx_q;

        pend_d       = bus.load ? {bus.value, bus.dp} : pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        // A load landing on the frame boundary bypasses the pending buffer.
        if (frame_end && bus.load) begin
            disp_d       = {bus.value, bus.dp};
            pend_valid_d = 1'b0;
        end else if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end else if (bus.load) begin
            pend_valid_d = 1'b1;
        end

        // Output registers look ahead to the slot and contents of the next cycle.
        nib   = disp_d[7:4];
        blank = 1'b0;
        dp_hi = disp_d[0];
        an_hi = 4'b0001;
        case (idx_d)
            DIG1: begin
                nib   = disp_d[11:8];
                blank = (disp_d[19:8] == 12'h000);
                dp_hi = disp_d[1];
                an_hi = 4'b0010;
            end
            DIG2: begin
                nib   = disp_d[15:12];
                blank = (disp_d[19:12] == 8'h00);
                dp_hi = disp_d[2];
                an_hi = 4'b0100;
            end
            DIG3: begin
                nib   = disp_d[19:16];
                blank = (disp_d[19:16] == 4'h0);
                dp_hi = disp_d[3];
                an_hi = 4'b1000;
            end
            default: ;
        endcase
        seg_hi = (blank && bus.blank_lz) ? 7'h00 : hex7(nib);

        an_d   = ACTIVE_LOW ? ~an_hi  : an_hi;
        seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_n_d = ACTIVE_LOW ? ~dp_hi  : dp_hi;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            div_q        <= '0;
            idx_q        <= DIG0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_n_q       <= DP_OFF;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_end;
endmodule
